// File: rtl/uart_frame_pkg.sv
// Shared constants for the framed UART transmitter: state encoding, frame delimiters, length-digit helper.
package uart_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ST_W   = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t HDR  = 3'd1;
    localparam state_t PAY  = 3'd2;
    localparam state_t CHK  = 3'd3;
    localparam state_t TRL  = 3'd4;

    localparam logic [BYTE_W-1:0] SOF0 = 8'h7B;
    localparam logic [BYTE_W-1:0] SOF1 = 8'h28;
    localparam logic [BYTE_W-1:0] EOF0 = 8'h29;
    localparam logic [BYTE_W-1:0] EOF1 = 8'h7D;

    // ASCII decimal digit of n; digit 0 is the thousands place.
    function automatic logic [BYTE_W-1:0] len_ascii(input int unsigned n, input int unsigned digit);
        int unsigned d;
        case (digit)
            0:       d = (n / 1000) % 10;
            1:       d = (n / 100) % 10;
            2:       d = (n / 10) % 10;
            default: d = n % 10;
        endcase
        return 8'(32'h30 + d);
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Show-ahead payload stream between the sample FIFO (master) and the frame transmitter (slave).
interface uart_frame_tx_if;
    import uart_frame_pkg::*;

    logic [BYTE_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/uart_tx_core.sv
// 8N1 bit engine: 10-bit shift register plus baud counter; accepts the next byte on the last stop-bit cycle.
module uart_tx_core
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              byte_rdy,
    output logic              tx
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd9;

    logic              active_q, active_d;
    logic [9:0]        shreg_q, shreg_d;
    logic [3:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              bit_end;

    // Shifting in ones leaves the line high once the stop bit has gone out.
    always_comb begin
        active_d = active_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        bit_end  = (baud_q == BAUD_LAST);
        byte_rdy = !active_q || (bit_end && (bit_q == BIT_LAST));

        if (byte_vld && byte_rdy) begin
            active_d = 1'b1;
            shreg_d  = {1'b1, byte_in, 1'b0};
            bit_d    = 4'd0;
            baud_d   = '0;
        end else if (active_q) begin
            if (bit_end) begin
                baud_d  = '0;
                shreg_d = {1'b1, shreg_q[9:1]};
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            shreg_q  <= '1;
            bit_q    <= 4'd0;
            baud_q   <= '0;
        end else begin
            active_q <= active_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
        end
    end

    assign tx = shreg_q[0];

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: "{(" + 4 length digits + payload [+ checksum] + ")}".
// Define UART_FRAME_CHECKSUM_EN to append the two's-complement payload checksum byte.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter  int unsigned       CLKS_PER_BIT = 434,
    parameter  int unsigned       PAYLOAD_LEN  = 1024,
    parameter  int unsigned       MAX_PEND     = 7,
    parameter  int unsigned       UNDERRUN_TMO = 65535,
    parameter  logic [BYTE_W-1:0] FILL_BYTE    = 8'h00,
    localparam int unsigned       PEND_W       = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_req,
    uart_frame_tx_if.slave    src,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [PEND_W-1:0] pending,
    output logic              req_drop,
    output logic              underrun
);

    localparam int unsigned       PAY_W    = $clog2(PAYLOAD_LEN + 1);
    localparam int unsigned       TMO_W    = (UNDERRUN_TMO > 0) ? $clog2(UNDERRUN_TMO + 1) : 1;
    localparam bit                TMO_EN   = (UNDERRUN_TMO != 0);
    localparam logic [PAY_W-1:0]  PAY_LAST = PAY_W'(PAYLOAD_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(UNDERRUN_TMO);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [2:0]        HDR_LAST = 3'd5;
    localparam logic [2:0]        TRL_WAIT = 3'd2;
    localparam logic [BYTE_W-1:0] LEN_D0   = len_ascii(PAYLOAD_LEN, 0);
    localparam logic [BYTE_W-1:0] LEN_D1   = len_ascii(PAYLOAD_LEN, 1);
    localparam logic [BYTE_W-1:0] LEN_D2   = len_ascii(PAYLOAD_LEN, 2);
    localparam logic [BYTE_W-1:0] LEN_D3   = len_ascii(PAYLOAD_LEN, 3);

    state_t            state_q, state_d;
    logic [2:0]        seq_q, seq_d;
    logic [PAY_W-1:0]  pay_q, pay_d;
    logic [TMO_W-1:0]  wait_q, wait_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              under_q, under_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
`endif

    logic              start;
    logic              tmo_hit;
    logic              pop;
    logic              byte_vld;
    logic              byte_rdy;
    logic [BYTE_W-1:0] byte_mux;

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        pay_d    = pay_q;
        wait_d   = wait_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        under_d  = under_q;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        byte_vld = 1'b0;
        byte_mux = 8'h00;
        pop      = 1'b0;
        start    = (state_q == IDLE) && (pend_q != '0) && enable;
        tmo_hit  = TMO_EN && (wait_q == TMO_LIM);

        // Request queue: a simultaneous request and start leaves the count unchanged.
        case ({frame_req, start})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR;
                    seq_d   = 3'd0;
                    pay_d   = '0;
                    wait_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            HDR: begin
                byte_vld = 1'b1;
                case (seq_q)
                    3'd0:    byte_mux = SOF0;
                    3'd1:    byte_mux = SOF1;
                    3'd2:    byte_mux = LEN_D0;
                    3'd3:    byte_mux = LEN_D1;
                    3'd4:    byte_mux = LEN_D2;
                    default: byte_mux = LEN_D3;
                endcase
                if (byte_rdy) begin
                    if (seq_q == HDR_LAST) begin
                        state_d = PAY;
                        seq_d   = 3'd0;
                    end else begin
                        seq_d = seq_q + 3'd1;
                    end
                end
            end
            PAY: begin
                // A real byte always wins over the timeout fill.
                byte_vld = src.s_valid || tmo_hit;
                byte_mux = src.s_valid ? src.s_data : FILL_BYTE;
                pop      = byte_rdy && src.s_valid;
                if (byte_rdy) begin
                    if (byte_vld) begin
                        wait_d = '0;
                        if (!src.s_valid) begin
                            under_d = 1'b1;
                        end
`ifdef UART_FRAME_CHECKSUM_EN
                        sum_d = sum_q + byte_mux;
`endif
                        if (pay_q == PAY_LAST) begin
                            pay_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = TRL;
`endif
                        end else begin
                            pay_d = pay_q + PAY_W'(1);
                        end
                    end else begin
                        wait_d = wait_q + TMO_W'(1);
                    end
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CHK: begin
                byte_vld = 1'b1;
                byte_mux = 8'h00 - sum_q;
                if (byte_rdy) begin
                    state_d = TRL;
                end
            end
`endif
            TRL: begin
                // Third slot sends nothing: it waits for the last stop bit to finish.
                byte_vld = (seq_q != TRL_WAIT);
                byte_mux = (seq_q == 3'd0) ? EOF0 : EOF1;
                if (byte_rdy) begin
                    if (seq_q == TRL_WAIT) begin
                        state_d = IDLE;
                        seq_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        seq_d = seq_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seq_q   <= 3'd0;
            pay_q   <= '0;
            wait_q  <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            under_q <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            pay_q   <= pay_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            under_q <= under_d;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .byte_vld (byte_vld),
        .byte_in  (byte_mux),
        .byte_rdy (byte_rdy),
        .tx       (tx)
    );

    assign src.s_ready = pop;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign pending     = pend_q;
    assign req_drop    = drop_q;
    assign underrun    = under_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: decodes tx with a bit-level receiver and checks frames, queueing and underrun.
module tb_uart_frame_tx;

    localparam int unsigned CPB    = 4;
    localparam int unsigned PLEN   = 4;
    localparam int unsigned MAXP   = 3;
    localparam int unsigned TMO    = 16;
    localparam int unsigned PEND_W = $clog2(MAXP + 1);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int unsigned FB = 13;
`else
    localparam int unsigned FB = 12;
`endif
    localparam int unsigned FRAME_CLKS = 10 * CPB * FB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic frame_req = 1'b0;
    logic tx, busy, frame_done, req_drop, underrun;
    logic [PEND_W-1:0] pending;

    uart_frame_tx_if bus();

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .PAYLOAD_LEN  (PLEN),
        .MAX_PEND     (MAXP),
        .UNDERRUN_TMO (TMO),
        .FILL_BYTE    (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_req  (frame_req),
        .src        (bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .pending    (pending),
        .req_drop   (req_drop),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-level receiver sampling mid-bit on falling edges.
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         fe_cnt = 0;

    initial begin : rx_mon
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx === 1'b1) begin
                    rx_q.push_back(b);
                    rx_cyc_q.push_back(t0);
                end else begin
                    fe_cnt++;
                end
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;
    int drop_cnt = 0;

    initial begin : evt_mon
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req_drop === 1'b1) drop_cnt++;
        end
    end

    // Show-ahead source; can stall for 60 cycles after a chosen pop.
    logic [7:0] src_q[$];
    int         pops = 0;
    int         stall_after = -1;
    int         stall_cnt = 0;

    initial begin : src_drv
        bit popped;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        forever begin
            @(negedge clk);
            popped = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
            @(posedge clk);
            #1;
            if (stall_cnt > 0) stall_cnt--;
            if (popped && src_q.size() > 0) begin
                void'(src_q.pop_front());
                pops++;
                if (pops == stall_after) stall_cnt = 60;
            end
            bus.s_valid = (src_q.size() > 0) && (stall_cnt == 0);
            bus.s_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick(1);
        frame_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, done_cnt, target);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc_q.delete();
    endtask

    function automatic int rx_start(input int idx);
        return (idx < rx_cyc_q.size()) ? rx_cyc_q[idx] : -100000;
    endfunction

    // Expected frame for PLEN=4: payload packed as {p0,p1,p2,p3}.
    task automatic check_frame(input string tag, input int base, input logic [31:0] pay);
        logic [7:0] e[$];
        logic [7:0] sum;
        logic [7:0] p;
        e   = '{8'h7B, 8'h28, 8'h30, 8'h30, 8'h30, 8'h34};
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            p = pay[31 - 8*i -: 8];
            e.push_back(p);
            sum = sum + p;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        e.push_back(8'h00 - sum);
`endif
        e.push_back(8'h29);
        e.push_back(8'h7D);
        for (int i = 0; i < e.size(); i++) begin
            check_eq($sformatf("%s_b%0d", tag, i),
                     (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hDEAD, {24'h0, e[i]});
        end
    endtask

    int req_cyc;
    int p0, d0, dr0;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : main
        tick(3);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_drop", req_drop, 0);
        check_eq("rst_underrun", underrun, 0);

        rst    = 1'b0;
        enable = 1'b1;
        tick(2);

        // Single clean frame with latency and duration checks.
        clear_rx();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        p0 = pops;
        d0 = done_cnt;
        frame_req = 1'b1;
        req_cyc   = cyc;
        tick(1);
        frame_req = 1'b0;
        tick(1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_pend", pending, 0);
        wait_done("t1_done", d0 + 1, 1000);
        tick(2);
        check_frame("t1", 0, 32'h01020304);
`ifdef UART_FRAME_CHECKSUM_EN
        check_eq("t1_chk_byte", (rx_q.size() > 10) ? {24'h0, rx_q[10]} : 32'hDEAD, 32'hF6);
`endif
        check_eq("t1_nbytes", rx_q.size(), FB);
        check_eq("t1_latency", rx_start(0) - req_cyc, 3);
        check_eq("t1_frame_clks", done_cyc - rx_start(0), FRAME_CLKS);
        check_eq("t1_pops", pops - p0, 4);
        check_eq("t1_underrun", underrun, 0);
        check_eq("t1_busy_end", busy, 0);

        // Pending saturation while busy, then three queued frames.
        clear_rx();
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h10 + i));
        p0  = pops;
        d0  = done_cnt;
        dr0 = drop_cnt;
        pulse_req();
        tick(3);
        check_eq("t2_busy", busy, 1);
        repeat (5) begin
            pulse_req();
            tick(1);
        end
        tick(1);
        check_eq("t2_pend_sat", pending, 3);
        check_eq("t2_drops", drop_cnt - dr0, 2);
        wait_done("t2_done", d0 + 4, 4 * 700);
        tick(2);
        check_eq("t2_nbytes", rx_q.size(), 4 * FB);
        check_eq("t2_span", rx_start(3 * FB) - rx_start(0), 3 * (FRAME_CLKS + 2));
        check_frame("t2f4", 3 * FB, 32'h1C1D1E1F);
        check_eq("t2_pend_end", pending, 0);
        check_eq("t2_pops", pops - p0, 16);

        // Source stall long enough to force one fill byte.
        clear_rx();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        p0 = pops;
        d0 = done_cnt;
        stall_after = pops + 2;
        pulse_req();
        wait_done("t3_done", d0 + 1, 1000);
        tick(2);
        check_frame("t3", 0, 32'h01020003);
        check_eq("t3_pops", pops - p0, 3);
        check_eq("t3_underrun", underrun, 1);
        stall_after = -1;
        src_q.delete();
        tick(2);

        // Enable dropped mid-payload: frame completes, queued frame waits.
        clear_rx();
        src_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        d0 = done_cnt;
        pulse_req();
        tick(300);
        enable = 1'b0;
        pulse_req();
        wait_done("t4_done_a", d0 + 1, 1000);
        tick(100);
        check_eq("t4_pend_hold", pending, 1);
        check_eq("t4_idle", busy, 0);
        check_eq("t4_no_start", done_cnt - d0, 1);
        check_frame("t4a", 0, 32'h21222324);
        enable = 1'b1;
        wait_done("t4_done_b", d0 + 2, 1000);
        tick(2);
        check_eq("t4_pend_end", pending, 0);
        check_frame("t4b", FB, 32'h25262728);
        check_eq("t4_framing", fe_cnt, 0);

        // Reset in mid-payload, then a clean frame.
        clear_rx();
        src_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        pulse_req();
        tick(300);
        pulse_req();
        check_eq("t5_pend_pre", pending, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("t5_tx", tx, 1);
        check_eq("t5_pend", pending, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_underrun_clr", underrun, 0);
        src_q.delete();
        tick(60);
        check_eq("t5_stays_idle", busy, 0);
        clear_rx();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        p0 = pops;
        d0 = done_cnt;
        pulse_req();
        wait_done("t5_done", d0 + 1, 1000);
        tick(2);
        check_frame("t5", 0, 32'h01020304);
        check_eq("t5_frame_clks", done_cyc - rx_start(0), FRAME_CLKS);
        check_eq("t5_pops", pops - p0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
